// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between instruction memory and decoder.
// Issues one sequential read per cycle to a one-cycle-latency memory and buffers
// returned words with their PCs in a DEPTH-entry FIFO drained by valid/ready.
// A redirect flushes the queue and restarts fetch at the target address.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to flag misaligned redirect
// targets (sticky o_fetch_err, fetch halts until reset). Without it the low two
// bits of the redirect target are dropped.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_ins_valid,
    output logic [31:0] o_ins,
    output logic [31:0] o_ins_pc,
    input  logic        i_ins_ready,
    output logic        o_fetch_err
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    logic [31:0]      r_fpc;
    logic [31:0]      r_mem_ins [DEPTH];
    logic [31:0]      r_mem_pc  [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_inflight;
    logic [31:0]      r_inflight_pc;
    logic             r_kill;

    logic [CNT_W-1:0] w_occupancy;
    logic             w_halted;
    logic             w_issue;
    logic             w_return;
    logic             w_push;
    logic             w_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_fetch_err;

    // Sticky error once a redirect target is not word aligned; cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_err <= 1'b0;
        end else if (i_redirect && (i_redirect_pc[1:0] != 2'b00)) begin
            r_fetch_err <= 1'b1;
        end
    end

    assign w_halted    = r_fetch_err;
    assign o_fetch_err = r_fetch_err;
`else
    assign w_halted    = 1'b0;
    assign o_fetch_err = 1'b0;
`endif

    // The in-flight read reserves a FIFO slot so its return always has room.
    assign w_occupancy = r_count + {{PTR_W{1'b0}}, r_inflight};
    assign w_issue     = i_rst_n & ~i_redirect & ~w_halted & (w_occupancy < DEPTH_C);
    assign w_return    = r_inflight & ~r_kill;
    assign w_push      = w_return & ~i_redirect;
    assign w_pop       = o_ins_valid & i_ins_ready;

    assign o_imem_req  = w_issue;
    assign o_imem_addr = r_fpc;
    assign o_ins_valid = (r_count != '0);
    assign o_ins       = r_mem_ins[r_rd_ptr];
    assign o_ins_pc    = r_mem_pc[r_rd_ptr];

    // Fetch pointer and in-flight tracking; a redirect discards everything in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fpc         <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_kill        <= 1'b0;
        end else if (i_redirect) begin
            r_fpc      <= i_redirect_pc & 32'hFFFF_FFFC;
            r_inflight <= 1'b0;
            r_kill     <= r_inflight;
        end else begin
            r_inflight <= w_issue;
            r_kill     <= 1'b0;
            if (w_issue) begin
                r_fpc         <= r_fpc + 32'd4;
                r_inflight_pc <= r_fpc;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: capture the returned word together with the PC it was fetched from.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_ins[i] <= '0;
                r_mem_pc[i]  <= '0;
            end
        end else if (w_push) begin
            r_mem_ins[r_wr_ptr] <= i_imem_rdata;
            r_mem_pc[r_wr_ptr]  <= r_inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue.
// The instruction memory model returns the request address as data one cycle
// later, so every delivered word must equal its PC.
module tb_fetch_queue;

    logic        clk;
    logic        rstN;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        insValid;
    logic [31:0] ins;
    logic [31:0] insPc;
    logic        insReady;
    logic        fetchErr;

    int nCompared   = 0;
    int nMismatched = 0;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .o_imem_req    (imemReq),
        .o_imem_addr   (imemAddr),
        .i_imem_rdata  (imemRdata),
        .i_redirect    (redirect),
        .i_redirect_pc (redirectPc),
        .o_ins_valid   (insValid),
        .o_ins         (ins),
        .o_ins_pc      (insPc),
        .i_ins_ready   (insReady),
        .o_fetch_err   (fetchErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency instruction memory that answers with the address itself.
    always @(posedge clk) begin
        imemRdata <= imemReq ? imemAddr : 32'hBAD0_BAD0;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstNIn, input logic readyIn, input logic redirIn, input logic [31:0] pcIn);
        rstN       = rstNIn;
        insReady   = readyIn;
        redirect   = redirIn;
        redirectPc = pcIn;
    endtask

    task automatic holdReset(input logic readyIn);
        applyStimulus(1'b0, readyIn, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int          nReq;
        logic        saw200;
        logic [31:0] k4;

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);

        // Reset state
        checkOutput("rst_ins_valid", 32'(insValid), 32'd0);
        checkOutput("rst_ins", ins, 32'h0);
        checkOutput("rst_ins_pc", insPc, 32'h0);
        checkOutput("rst_imem_req", 32'(imemReq), 32'd0);
        checkOutput("rst_imem_addr", imemAddr, 32'h0);
        checkOutput("rst_fetch_err", 32'(fetchErr), 32'd0);

        // Streaming with ins_ready held high
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("c0_req", 32'(imemReq), 32'd1);
        checkOutput("c0_addr", imemAddr, 32'h0);
        @(negedge clk);
        checkOutput("c1_valid", 32'(insValid), 32'd0);
        @(negedge clk);
        checkOutput("c2_valid", 32'(insValid), 32'd1);
        checkOutput("c2_pc", insPc, 32'h0);
        checkOutput("c2_ins", ins, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            k4 = 32'(k * 4);
            checkOutput("stream_valid", 32'(insValid), 32'd1);
            checkOutput("stream_pc", insPc, k4);
            checkOutput("stream_ins", ins, k4);
        end

        // Fill with ins_ready low: exactly four requests, then drain in order
        holdReset(1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        nReq = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (imemReq) nReq++;
            @(negedge clk);
        end
        checkOutput("full_nreq", 32'(nReq), 32'd4);
        checkOutput("full_req", 32'(imemReq), 32'd0);
        checkOutput("full_addr", imemAddr, 32'h10);
        checkOutput("full_valid", 32'(insValid), 32'd1);
        checkOutput("full_head", insPc, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            k4 = 32'(k * 4);
            checkOutput("drain_pc", insPc, k4);
            checkOutput("drain_ins", ins, k4);
        end

        // Redirect with three queued entries and one read in flight
        holdReset(1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (4) @(negedge clk);
        checkOutput("pre_redir_valid", 32'(insValid), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h100);
        #1;
        checkOutput("redir_R_req", 32'(imemReq), 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("redir_R1_valid", 32'(insValid), 32'd0);
        checkOutput("redir_R1_req", 32'(imemReq), 32'd1);
        checkOutput("redir_R1_addr", imemAddr, 32'h100);
        @(negedge clk);
        checkOutput("redir_R2_valid", 32'(insValid), 32'd0);
        @(negedge clk);
        checkOutput("redir_R3_valid", 32'(insValid), 32'd1);
        checkOutput("redir_R3_pc", insPc, 32'h100);
        checkOutput("redir_R3_ins", ins, 32'h100);
        @(negedge clk);
        checkOutput("redir_R4_pc", insPc, 32'h104);

        // Back-to-back redirects: only the second target is fetched
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h300);
        #1;
        saw200 = insValid && (insPc[31:8] == 24'h2);
        checkOutput("b2b_A1_req", 32'(imemReq), 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        saw200 = saw200 | (insValid && (insPc[31:8] == 24'h2));
        checkOutput("b2b_A2_addr", imemAddr, 32'h300);
        @(negedge clk);
        saw200 = saw200 | (insValid && (insPc[31:8] == 24'h2));
        checkOutput("b2b_A3_valid", 32'(insValid), 32'd0);
        @(negedge clk);
        checkOutput("b2b_A4_valid", 32'(insValid), 32'd1);
        checkOutput("b2b_A4_pc", insPc, 32'h300);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            saw200 = saw200 | (insValid && (insPc[31:8] == 24'h2));
        end
        checkOutput("b2b_no_0x200", 32'(saw200), 32'd0);
        checkOutput("b2b_tail_pc", insPc, 32'h30C);

        // Asynchronous reset mid-stream with two entries queued
        holdReset(1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("pre_arst_valid", 32'(insValid), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("arst_valid", 32'(insValid), 32'd0);
        checkOutput("arst_req", 32'(imemReq), 32'd0);
        checkOutput("arst_addr", imemAddr, 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("rest_c0_addr", imemAddr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rest_c2_valid", 32'(insValid), 32'd1);
        checkOutput("rest_c2_pc", insPc, 32'h0);

        // Misaligned redirect target
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h102);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput("mis_err", 32'(fetchErr), 32'd1);
        checkOutput("mis_req", 32'(imemReq), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("mis_hold_valid", 32'(insValid), 32'd0);
        checkOutput("mis_hold_req", 32'(imemReq), 32'd0);
        checkOutput("mis_hold_err", 32'(fetchErr), 32'd1);
        holdReset(1'b1);
        checkOutput("mis_rst_err", 32'(fetchErr), 32'd0);
`else
        checkOutput("mis_err", 32'(fetchErr), 32'd0);
        checkOutput("mis_req", 32'(imemReq), 32'd1);
        checkOutput("mis_addr", imemAddr, 32'h100);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mis_valid", 32'(insValid), 32'd1);
        checkOutput("mis_pc", insPc, 32'h100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction memory and the decoder of the RV32I core. Generates sequential fetch addresses, issues one read per cycle to a fixed-latency instruction memory, and buffers returned words with their PCs in a small FIFO. The decoder drains the FIFO through a valid/ready handshake. A branch redirect from the ALU flushes the queue and restarts fetch at the target.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, first fetch address after reset

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  read request this cycle
- imem_addr  out  32  read address, word aligned in normal operation
- imem_rdata  in  32  read data, valid exactly one cycle after the matching imem_req
- redirect  in  1  flush and restart fetch (branch/jump taken)
- redirect_pc  in  32  restart address, sampled when redirect=1
- ins_valid  out  1  head entry valid
- ins  out  32  head instruction word
- ins_pc  out  32  PC of head instruction
- ins_ready  in  1  decoder accepts head this cycle
- fetch_err  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State: fetch pointer fpc (32b), FIFO of {pc, word} × DEPTH, rd/wr pointers wrapping mod DEPTH, count (0..DEPTH), one in-flight flag with its PC and a kill bit.
- Issue: imem_req=1 when rst deasserted, redirect=0, and count + inflight < DEPTH. imem_addr = fpc. On issue, fpc ← fpc+4 (wraps modulo 2^32), in-flight set with pc=fpc, kill=0.
- Return: cycle after an issue, imem_rdata written at wr pointer with the in-flight PC unless kill=1; the in-flight flag then clears (or is re-set by a same-cycle issue).
- Dequeue: ins_valid&ins_ready pops head. Enqueue and dequeue in the same cycle are both honoured; count unchanged.
- ins_valid = (count≠0); ins/ins_pc = head entry, combinational from FIFO storage.
- Redirect (highest priority): at the clock edge, count←0, pointers←0, fpc←redirect_pc, any in-flight response marked kill=1, no issue that cycle. A handshake completing in the redirect cycle counts as consumed; nothing else survives.
- Full: count+inflight = DEPTH → imem_req=0; fpc holds.
- Empty: ins_valid=0; ins/ins_pc hold stale values and are don't-care.

## Timing
- Reset (rst=0, async): ins_valid=0, ins=0, ins_pc=0, imem_req=0, imem_addr=RESET_PC, fetch_err=0, count=0, in-flight cleared. Reset mid-operation discards queue and in-flight data immediately.
- Cycle 0 = first cycle with rst=1: imem_req=1, imem_addr=RESET_PC. Cycle 1: data captured. Cycle 2: ins_valid=1, ins_pc=RESET_PC.
- Request-to-valid latency 2 cycles; steady-state throughput 1 instruction/cycle when ins_ready held high.
- Redirect sampled in cycle R: cycle R+1 imem_req=1 at redirect_pc, and the response arriving in R+1 is discarded; earliest ins_valid for target at R+3.
- Back-to-back redirects: each restarts; only the last target is fetched.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0]≠0 sets fetch_err (sticky until reset). Fetch halts: imem_req=0, queue stays empty until reset.
- Not defined: fetch_err tied 0; redirect_pc[1:0] ignored and forced to 0 in fpc.

## Test plan
- Reset release, ins_ready=1, imem returns addr-as-data → ins_valid at cycle 2, ins_pc sequence 0,4,8,… one per cycle, ins equal to ins_pc.
- ins_ready=0 from cycle 0 → exactly DEPTH=4 requests issued (0..C), imem_req low afterwards, count=4; then ins_ready=1 → pops 0,4,8,C in order and fetch resumes at 0x10.
- Redirect to 0x100 while queue holds 3 entries and one request is in flight → queue empty next cycle, stale response dropped, imem_addr=0x100 at R+1, ins_pc=0x100 at R+3.
- Redirects in two consecutive cycles (0x200 then 0x300) → no 0x200 word ever delivered; first ins_pc=0x300.
- rst pulsed low mid-stream with 2 entries queued → ins_valid=0 immediately; fetch restarts at RESET_PC.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 → fetch_err=1, imem_req=0, ins_valid=0 until reset; without it, fetch resumes at 0x100.
